// File: rtl/wb_pipelined_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pipelined_slave
//  Purpose  : Wishbone B4 pipelined slave model. Holds a byte-addressable word
//             memory, accepts up to MAX_OUTSTANDING requests and acks them in
//             order after a minimum latency. Bench hooks add forced stall,
//             ack hold-off and read-data injection.
//  Revision : 1.0  initial release
// ============================================================================
module wb_pipelined_slave #(
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic        stall_request_i,
  input  logic        ack_hold_i,
  input  logic        inject_valid_i,
  input  logic [31:0] injected_data_i,
  output logic [4:0]  outstanding_o
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              PW         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int              SLOTS      = 1 << PW;
  localparam logic [4:0]      FULL_COUNT = 5'(MAX_OUTSTANDING);
  localparam logic [4:0]      LAT5       = 5'(LATENCY);
  localparam logic [3:0]      LAT4       = 4'(LATENCY);
  localparam logic [PW-1:0]   LAST_SLOT  = PW'(MAX_OUTSTANDING - 1);

  logic [31:0]   mem       [DEPTH];
  logic [31:0]   fifo_data [SLOTS];
  logic [3:0]    fifo_age  [SLOTS];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [4:0]    count;

  logic [AW-1:0] word_idx;
  logic          accept;
  logic          pop;
  logic [31:0]   push_data;
  logic [4:0]    head_elapsed;
  logic          unused_adr;

  // Circular pointer advance; wraps at the configured depth even when
  // MAX_OUTSTANDING is 1 and the pointer has a spare bit.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  assign word_idx   = wb_adr_i[AW+1:2];
  assign unused_adr = &{1'b0, wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  // A full FIFO stalls regardless of a pop happening in the same cycle.
  assign wb_stall_o    = stall_request_i | (count == FULL_COUNT);
  assign accept        = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign outstanding_o = count;

  // Stored age is the number of edges seen since the push; the edge being
  // evaluated counts as one more, so the head may pop once that reaches
  // LATENCY. A request accepted at edge N therefore acks in cycle N+LATENCY.
  assign head_elapsed = {1'b0, fifo_age[rd_ptr]} + 5'd1;
  assign pop          = wb_cyc_i & ~ack_hold_i & (count != 5'd0) & (head_elapsed >= LAT5);

  // Writes carry no data back; reads take the current word or the override.
  assign push_data = wb_we_i        ? 32'd0 :
                     inject_valid_i ? injected_data_i : mem[word_idx];

  // Memory: cleared on reset, byte-lane update on an accepted write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Request FIFO, ageing, in-order registered ack and abort handling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        fifo_data[i] <= '0;
        fifo_age[i]  <= '0;
      end
    end else begin
      wb_ack_o <= pop;
      wb_dat_o <= pop ? fifo_data[rd_ptr] : 32'd0;

      // Entries keep ageing even while the pop is held off.
      for (int i = 0; i < SLOTS; i++) begin
        if (fifo_age[i] < LAT4) begin
          fifo_age[i] <= fifo_age[i] + 4'd1;
        end
      end

      if (!wb_cyc_i) begin
        // Abort drops every pending request; nothing can ack late.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) begin
          fifo_data[wr_ptr] <= push_data;
          fifo_age[wr_ptr]  <= '0;
          wr_ptr            <= next_ptr(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        case ({accept, pop})
          2'b10:   count <= count + 5'd1;
          2'b01:   count <= count - 5'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
